sha256_msg_padder: RTL and testbench

Streaming pre-processor that sits directly upstream of the SHA-256 compression core. It accepts a message as a stream of 32-bit big-endian words and emits the fully padded stream as 512-bit blocks, sent as 16 words each. Padding is the 0x80000000 marker word, then zero words, then the 64-bit message bit-length. The core therefore never computes padding or block counts itself. Messages are whole words only, with at least 1 word.

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_out_reg.sv | 47 ++++
 rtl/sha256_msg_padder.sv | 173 +++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
//   pad_state_e    : padder sequencing states
//   pad_word_t     : one output-stage payload {data, eob, eom}
//   blocks_per_msg : blocks produced for a message of N words
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned LEN_HI_IDX  = 14;
  localparam logic [WORD_W-1:0] SHA256_PAD_WORD = 32'h8000_0000;

  typedef enum logic [2:0] {
    PASS  = 3'd0,
    PAD   = 3'd1,
    ZFILL = 3'd2,
    ZERO  = 3'd3,
    LENH  = 3'd4,
    LENL  = 3'd5
  } pad_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              eob;
    logic              eom;
  } pad_word_t;

  // Message words plus marker plus two length words, rounded up to blocks.
  function automatic int unsigned blocks_per_msg(input int unsigned words);
    return (words + 3 + BLOCK_WORDS - 1) / BLOCK_WORDS;
  endfunction

endpackage

// File: rtl/sha256_out_reg.sv
// One-entry valid/ready output register.
//   push/push_word : load request (only asserted while ready_c is high)
//   out_valid/out_word/out_ready : downstream handshake
//   ready_c        : register can take a word this cycle
module sha256_out_reg
  import sha256_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  pad_word_t push_word,
  input  logic      out_ready,
  output logic      out_valid,
  output pad_word_t out_word,
  output logic      ready_c
);

  logic      valid_q, valid_d;
  pad_word_t word_q, word_d;

  assign ready_c   = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_word  = word_q;

  // Load on push, otherwise drain when the consumer takes the word.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (push) begin
      valid_d = 1'b1;
      word_d  = push_word;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: forwards 32-bit message words and appends the
// marker word, zero fill and 64-bit bit-length, emitting whole 16-word blocks.
//   in_*  : message word stream (in_last marks the final word)
//   out_* : padded stream; out_eob on word 15 of each block, out_eom on the
//           final length word
//   busy  : message in progress
// Optional: SHA256_PAD_STATS_EN adds msg_cnt / blk_cnt accepted counters.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_eob,
  output logic              out_eom,
  output logic              busy
`ifdef SHA256_PAD_STATS_EN
  ,
  output logic [15:0]       msg_cnt,
  output logic [15:0]       blk_cnt
`endif
);

  pad_state_e       state_q, state_d;
  logic [IDX_W-1:0] wi_q, wi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             init_q, init_d;

  logic      push;
  pad_word_t push_word;
  pad_word_t out_word;
  logic      ready_c;
  logic      in_fire;
  logic      out_fire;
  logic [63:0] bit_len;

  assign bit_len  = 64'({cnt_q, 5'b0});
  // init_q keeps in_ready low while reset is applied.
  assign in_ready = init_q && (state_q == PASS) && ready_c;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Sequencing: every state transition happens on a word loaded to the output.
  always_comb begin
    state_d        = state_q;
    wi_d           = wi_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    init_d         = 1'b1;
    push           = 1'b0;
    push_word.data = '0;
    push_word.eob  = (wi_q == IDX_W'(BLOCK_WORDS - 1));
    push_word.eom  = 1'b0;

    if (out_fire && out_eom) busy_d = 1'b0;

    case (state_q)
      PASS: begin
        push_word.data = in_data;
        if (in_fire) begin
          push   = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          if (in_last) state_d = PAD;
        end
      end
      PAD: begin
        push           = ready_c;
        push_word.data = SHA256_PAD_WORD;
        if (ready_c) begin
          if (wi_q < IDX_W'(LEN_HI_IDX - 1))       state_d = ZERO;
          else if (wi_q == IDX_W'(LEN_HI_IDX - 1)) state_d = LENH;
          else if (wi_q == IDX_W'(LEN_HI_IDX))     state_d = ZFILL;
          else                                     state_d = ZERO;  // marker at 15: next block is zeros
        end
      end
      ZFILL: begin
        push = ready_c;
        if (ready_c && wi_q == IDX_W'(BLOCK_WORDS - 1)) state_d = ZERO;
      end
      ZERO: begin
        push = ready_c;
        if (ready_c && wi_q == IDX_W'(LEN_HI_IDX - 1)) state_d = LENH;
      end
      LENH: begin
        push           = ready_c;
        push_word.data = bit_len[63:32];
        if (ready_c) state_d = LENL;
      end
      LENL: begin
        push           = ready_c;
        push_word.data = bit_len[31:0];
        push_word.eom  = 1'b1;
        if (ready_c) begin
          cnt_d   = '0;
          state_d = PASS;
        end
      end
      default: state_d = PASS;
    endcase

    // LENL sits at index 15, so the wrap here also realigns wi to 0.
    if (push) wi_d = wi_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PASS;
      wi_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
    end
  end

  sha256_out_reg u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_word (push_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .ready_c   (ready_c)
  );

  assign out_data = out_word.data;
  assign out_eob  = out_word.eob;
  assign out_eom  = out_word.eom;
  assign busy     = busy_q;

`ifdef SHA256_PAD_STATS_EN
  logic [15:0] msg_cnt_q, msg_cnt_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;

  // Count messages and blocks as the consumer accepts their final words.
  always_comb begin
    msg_cnt_d = msg_cnt_q;
    blk_cnt_d = blk_cnt_q;
    if (out_fire && out_eom) msg_cnt_d = msg_cnt_q + 16'd1;
    if (out_fire && out_eob) blk_cnt_d = blk_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      msg_cnt_q <= msg_cnt_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign msg_cnt = msg_cnt_q;
  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized scoreboard bench for sha256_msg_padder.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_eob;
  logic        out_eom;
  logic        busy;
`ifdef SHA256_PAD_STATS_EN
  logic [15:0] msg_cnt;
  logic [15:0] blk_cnt;
`endif

  sha256_msg_padder #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eob   (out_eob),
    .out_eom   (out_eom),
    .busy      (busy)
`ifdef SHA256_PAD_STATS_EN
    ,
    .msg_cnt   (msg_cnt),
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        eob;
    logic        eom;
  } exp_t;

  exp_t        expq[$];
  int unsigned blkq[$];
  exp_t        plan[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;
  bit          padding = 1'b0;
  int unsigned msgs_done = 0;
  int unsigned blks_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: message, marker, zeros until 2 slots remain in a block, 64-bit bit length.
  task automatic build_plan(input logic [31:0] w[$]);
    logic [31:0] s[$];
    logic [63:0] bits;
    s = w;
    bits = 64'(w.size()) * 64'd32;
    s.push_back(32'h8000_0000);
    while ((s.size() % 16) != 14) s.push_back(32'h0);
    s.push_back(bits[63:32]);
    s.push_back(bits[31:0]);
    plan.delete();
    foreach (s[i]) begin
      exp_t e;
      e.d   = s[i];
      e.eob = ((i % 16) == 15);
      e.eom = (i == s.size() - 1);
      plan.push_back(e);
    end
  endtask

  // Downstream ready generator: 0 always ready, 1 pattern 1-0-0-1, 2 random.
  initial begin
    int pc = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pc++;
    end
  end

  // Monitor: pops the scoreboard on every accepted output word.
  initial begin
    bit          held = 1'b0;
    logic [31:0] hd;
    logic        heob, heom;
    int unsigned blk_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        blk_seen = 0;
        continue;
      end
      if (held) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(hd));
        check("stall_flags", 64'({out_eob, out_eom}), 64'({heob, heom}));
      end
      held = out_valid && !out_ready;
      hd = out_data; heob = out_eob; heom = out_eom;
      if (padding && expq.size() > 1) check("in_ready_pad", 64'(in_ready), 64'd0);
      if (in_ready) check("in_ready_space", 64'(!out_valid || out_ready), 64'd1);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_word", 64'(out_data), 64'hDEAD);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("out_data", 64'(out_data), 64'(e.d));
          check("out_eob", 64'(out_eob), 64'(e.eob));
          check("out_eom", 64'(out_eom), 64'(e.eom));
          if (out_eob) begin
            blk_seen++;
            blks_done++;
          end
          if (out_eom) begin
            check("blocks_per_msg", 64'(blk_seen), 64'(blkq.size() ? blkq.pop_front() : 0));
            blk_seen = 0;
            padding = 1'b0;
            msgs_done++;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends a message of n words; abort_at>0 stops after that many words.
  task automatic send_msg(input int unsigned n, input logic [31:0] w0, input bit fix_w0,
                          input int unsigned abort_at, input bit gaps);
    logic [31:0] w[$];
    int unsigned nd;
    for (int unsigned i = 0; i < n; i++) w.push_back((i == 0 && fix_w0) ? w0 : $urandom());
    build_plan(w);
    for (int unsigned i = 0; i < n; i++) begin
      if (abort_at != 0 && i == abort_at) return;
      send_word(w[i], i == n - 1);
      expq.push_back(plan[i]);
      if (i == 0) check("busy_set", 64'(busy), 64'd1);
      if (i == n - 1) begin
        nd = plan.size();
        for (int unsigned k = n; k < nd; k++) expq.push_back(plan[k]);
        blkq.push_back((n + 3 + 15) / 16);
        padding = 1'b1;
      end
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_last = 1'($urandom_range(0, 1));
          in_data = $urandom();
          @(posedge clk); #1;
        end
        in_last = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 64'(expq.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_idle", 64'(busy), 64'd0);
`ifdef SHA256_PAD_STATS_EN
    check("msg_cnt", 64'(msg_cnt), 64'(16'(msgs_done)));
    check("blk_cnt", 64'(blk_cnt), 64'(16'(blks_done)));
`endif
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_flags", 64'({out_eob, out_eom}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
  endtask

  initial begin
    int unsigned lens[6] = '{13, 15, 29, 30, 31, 32};
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    rdy_mode = 0;
    send_msg(1, 32'h6162_6364, 1'b1, 0, 1'b0); drain();
    send_msg(14, 32'h0, 1'b0, 0, 1'b0);        drain();
    send_msg(16, 32'h0, 1'b0, 0, 1'b0);        drain();
    send_msg(40, 32'h0, 1'b0, 0, 1'b0);        drain();

    rdy_mode = 1;
    send_msg(40, 32'h0, 1'b0, 0, 1'b0);        drain();

    rdy_mode = 2;
    foreach (lens[i]) send_msg(lens[i], 32'h0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 6; i++) send_msg($urandom_range(1, 50), 32'h0, 1'b0, 0, 1'b1);
    drain();

    // Abandon a message mid-stream with reset, then send a fresh one.
    rdy_mode = 1;
    send_msg(20, 32'h0, 1'b0, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    expq.delete();
    blkq.delete();
    padding = 1'b0;
    msgs_done = 0;
    blks_done = 0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_msg(1, 32'h0000_0001, 1'b1, 0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
